bnode: RTL and testbench
========================

# bnode

Bitonic sorting node that sorts NUM_COUNT unsigned lanes of DATA_WIDTH bits into ascending or descending order. It is the sorting core of the bitonic sorter wrapper. The wrapper registers the input vector, then captures data_out on the next clock edge, so the sort path is purely combinational with zero-cycle latency. The node is defined recursively: two half-size nodes of opposite polarity feed a bitonic merge.

## Interface
Parameters:
- NUM_COUNT, default 2: number of lanes. Must be a power of two, ≥ 1.
- DATA_WIDTH, default 8: bits per lane. Must be ≥ 1.

Ports:
- clk, input, 1: clock. Present for wrapper compatibility; no registers in the data path.
- reset, input, 1: synchronous, active-high reset. Has no effect on data_out.
- data_in, input, NUM_COUNT*DATA_WIDTH: lane i is bits [i*DATA_WIDTH +: DATA_WIDTH].
- polarity, input, 1:
  - 0 = ascending: lane 0 holds the minimum, lane NUM_COUNT-1 the maximum.
  - 1 = descending: lane 0 holds the maximum.
- data_out, output, NUM_COUNT*DATA_WIDTH: sorted permutation of data_in, same lane packing.

## Operation
- Comparisons are unsigned, at full DATA_WIDTH. There is no widening or truncation.
- data_out is always an exact permutation of data_in. Equal values are interchangeable, so no stability requirement applies.
- Recursion on NUM_COUNT = N:
  - N = 1: data_out = data_in; polarity is ignored.
  - N ≥ 2: the lower half (lanes 0..N/2-1) is sorted ascending by a child bnode with polarity 0. The upper half (lanes N/2..N-1) is sorted descending by a child with polarity 1. This forms a bitonic sequence, which a bitonic merge of size N then sorts into the requested polarity.
- Bitonic merge of size M with direction d:
  - For i in 0..M/2-1, compare-exchange lanes i and i+M/2. For d = ascending, the smaller value goes to lane i; for d = descending, the larger.
  - Then recursively merge each half with the same d. M = 1 is a pass-through.
- Compare-exchange stages: log2(N)·(log2(N)+1)/2.
- Comparators: N/4·log2(N)·(log2(N)+1).

## Timing
- Fully combinational from data_in and polarity to data_out; latency is 0 cycles.
- The result must settle within one clk period at the target frequency. This is the wrapper's WAIT→SORTING→DONE capture edge.
- No internal state, so no state machine.
  - reset asserted, deasserted, or toggled mid-operation does not alter data_out.
  - Simultaneous changes of data_in and polarity simply produce the new sort.
- There are no X-propagation sources other than X inputs.

## Structure
- Shared package (bitonic_pkg):
  - An unsigned compare-exchange function taking two lanes and a direction, returning a low/high pair.
  - Polarity constants: ASCENDING = 1'b0, DESCENDING = 1'b1.
- One sub-module, bmerge #(NUM_COUNT, DATA_WIDTH): direction input, data_in, data_out.
  - Implemented recursively through generate; it instantiates two half-size bmerge instances.
- bnode instantiates:
  - two half-size bnode children, each passing clk and reset through;
  - one bmerge of full size.
- Elaboration-time assertions: NUM_COUNT is a power of two, and DATA_WIDTH ≥ 1.

## Test plan
- N=2, W=8, polarity 0, lanes [0]=0x05, [1]=0x03 → data_out lanes [0]=0x03, [1]=0x05. With polarity 1, same input → [0]=0x05, [1]=0x03.
- N=8, W=8, polarity 0, lanes 0..7 = 7,3,9,1,0xFF,0,4,4 → 0,1,3,4,4,7,9,0xFF. Polarity 1 → exact reverse.
- Unsigned check, N=4, W=8: lanes 0x80,0x7F,0x01,0xFE, polarity 0 → 0x01,0x7F,0x80,0xFE. 0x80 must sort above 0x7F.
- Already-sorted and all-equal inputs (N=4, all 0xAA) → output equals input, for either polarity.
- Reset independence: hold reset=1 across several clk edges while changing data_in → data_out tracks the sort combinationally in the same cycle. Result is identical after reset drops.
- Randomized N=16, W=8, 1000 vectors per polarity, checked against a reference sort. Confirm zero-latency and that the output is a permutation of the input (multiset equality).

Source files
------------

// File: rtl/bitonic_pkg.sv
// Shared definitions for the bitonic sorter: polarity encodings and the
// unsigned compare-exchange primitive used by every merge stage.
package bitonic_pkg;

    localparam logic ASCENDING  = 1'b0;
    localparam logic DESCENDING = 1'b1;

    // Lane width varies per instance, so the primitive sits in a
    // width-parameterised class as a static function.
    // Result packing: {value for the upper lane, value for the lower lane}.
    // Ascending puts the smaller value in the lower lane; descending puts
    // the larger one there.
    virtual class cx_ops #(parameter int unsigned WIDTH = 8);
        static function logic [2*WIDTH-1:0] exchange(
            input logic [WIDTH-1:0] a,
            input logic [WIDTH-1:0] b,
            input logic             dir
        );
            logic [WIDTH-1:0] lo;
            logic [WIDTH-1:0] hi;
            if (a > b) begin
                lo = b;
                hi = a;
            end else begin
                lo = a;
                hi = b;
            end
            return (dir == DESCENDING) ? {lo, hi} : {hi, lo};
        endfunction
    endclass

endpackage

// File: rtl/bmerge.sv
// Recursive bitonic merge: one compare-exchange column across the two
// halves, then each half is merged again in the same direction.
module bmerge
    import bitonic_pkg::*;
#(
    parameter int unsigned NUM_COUNT  = 2,
    parameter int unsigned DATA_WIDTH = 8
) (
    input  logic                            direction,
    input  logic [NUM_COUNT*DATA_WIDTH-1:0] data_in,
    output logic [NUM_COUNT*DATA_WIDTH-1:0] data_out
);

    localparam int unsigned HALF = NUM_COUNT / 2;

    if (NUM_COUNT == 1) begin : g_leaf
        assign data_out = data_in;
    end else begin : g_node
        logic [NUM_COUNT*DATA_WIDTH-1:0] stage;

        // Lane i is paired with lane i+HALF.
        for (genvar i = 0; i < HALF; i++) begin : g_cx
            assign {stage[(i+HALF)*DATA_WIDTH +: DATA_WIDTH],
                    stage[i*DATA_WIDTH +: DATA_WIDTH]} =
                cx_ops#(DATA_WIDTH)::exchange(
                    data_in[i*DATA_WIDTH +: DATA_WIDTH],
                    data_in[(i+HALF)*DATA_WIDTH +: DATA_WIDTH],
                    direction);
        end

        bmerge #(
            .NUM_COUNT (HALF),
            .DATA_WIDTH(DATA_WIDTH)
        ) u_lo (
            .direction(direction),
            .data_in  (stage[HALF*DATA_WIDTH-1:0]),
            .data_out (data_out[HALF*DATA_WIDTH-1:0])
        );

        bmerge #(
            .NUM_COUNT (HALF),
            .DATA_WIDTH(DATA_WIDTH)
        ) u_hi (
            .direction(direction),
            .data_in  (stage[NUM_COUNT*DATA_WIDTH-1:HALF*DATA_WIDTH]),
            .data_out (data_out[NUM_COUNT*DATA_WIDTH-1:HALF*DATA_WIDTH])
        );
    end

endmodule

// File: rtl/bnode.sv
// Bitonic sorting node: two half-size nodes of opposite polarity build a
// bitonic sequence that a full-size merge sorts into the requested order.
// Purely combinational; clk and reset only pass through to the children.
module bnode
    import bitonic_pkg::*;
#(
    parameter int unsigned NUM_COUNT  = 2,
    parameter int unsigned DATA_WIDTH = 8
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic [NUM_COUNT*DATA_WIDTH-1:0] data_in,
    input  logic                            polarity,
    output logic [NUM_COUNT*DATA_WIDTH-1:0] data_out
);

    localparam int unsigned HALF = NUM_COUNT / 2;

    if (NUM_COUNT < 1 || (NUM_COUNT & (NUM_COUNT - 1)) != 0) begin : g_bad_count
        $error("bnode: NUM_COUNT must be a power of two >= 1");
    end
    if (DATA_WIDTH < 1) begin : g_bad_width
        $error("bnode: DATA_WIDTH must be >= 1");
    end

    if (NUM_COUNT == 1) begin : g_leaf
        // A single lane is already sorted; the remaining inputs are unused.
        logic unused_inputs;
        assign unused_inputs = ^{clk, reset, polarity};
        assign data_out      = data_in;
    end else begin : g_node
        logic [NUM_COUNT*DATA_WIDTH-1:0] bitonic;

        bnode #(
            .NUM_COUNT (HALF),
            .DATA_WIDTH(DATA_WIDTH)
        ) u_lo (
            .clk     (clk),
            .reset   (reset),
            .data_in (data_in[HALF*DATA_WIDTH-1:0]),
            .polarity(ASCENDING),
            .data_out(bitonic[HALF*DATA_WIDTH-1:0])
        );

        bnode #(
            .NUM_COUNT (HALF),
            .DATA_WIDTH(DATA_WIDTH)
        ) u_hi (
            .clk     (clk),
            .reset   (reset),
            .data_in (data_in[NUM_COUNT*DATA_WIDTH-1:HALF*DATA_WIDTH]),
            .polarity(DESCENDING),
            .data_out(bitonic[NUM_COUNT*DATA_WIDTH-1:HALF*DATA_WIDTH])
        );

        bmerge #(
            .NUM_COUNT (NUM_COUNT),
            .DATA_WIDTH(DATA_WIDTH)
        ) u_merge (
            .direction(polarity),
            .data_in  (bitonic),
            .data_out (data_out)
        );
    end

endmodule

// File: tb/tb_bnode.sv
// Directed and randomized checks of bnode at several lane counts.
module tb_bnode;

    logic clk   = 1'b0;
    logic reset = 1'b1;

    always #5 clk = ~clk;

    logic [15:0]  in2,  out2;
    logic [31:0]  in4,  out4;
    logic [63:0]  in8,  out8;
    logic [127:0] in16, out16;
    logic         pol2, pol4, pol8, pol16;

    int unsigned n_cmp = 0;
    int unsigned n_bad = 0;

    bnode #(.NUM_COUNT(2), .DATA_WIDTH(8)) dut2 (
        .clk(clk), .reset(reset), .data_in(in2), .polarity(pol2), .data_out(out2));
    bnode #(.NUM_COUNT(4), .DATA_WIDTH(8)) dut4 (
        .clk(clk), .reset(reset), .data_in(in4), .polarity(pol4), .data_out(out4));
    bnode #(.NUM_COUNT(8), .DATA_WIDTH(8)) dut8 (
        .clk(clk), .reset(reset), .data_in(in8), .polarity(pol8), .data_out(out8));
    bnode #(.NUM_COUNT(16), .DATA_WIDTH(8)) dut16 (
        .clk(clk), .reset(reset), .data_in(in16), .polarity(pol16), .data_out(out16));

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Drive away from the rising edge and sample 1 time unit later.
    task automatic settle();
        @(negedge clk);
        #1;
    endtask

    logic [7:0]  lanes  [16];
    logic [7:0]  sorted [16];
    logic [7:0]  tmp;
    logic [127:0] exp16;
    int          hist [256];
    logic        perm_ok;

    initial begin
        in2 = '0; in4 = '0; in8 = '0; in16 = '0;
        pol2 = 1'b0; pol4 = 1'b0; pol8 = 1'b0; pol16 = 1'b0;

        // Output follows input even while reset is asserted.
        in2 = 16'h0305;
        settle();
        check("n2_asc_in_reset", 128'(out2), 128'h0503);
        reset = 1'b0;
        pol2 = 1'b1;
        settle();
        check("n2_desc", 128'(out2), 128'h0305);

        in8 = 64'h0404_00FF_0109_0307;
        pol8 = 1'b0;
        settle();
        check("n8_asc", 128'(out8), 128'hFF09_0704_0403_0100);
        pol8 = 1'b1;
        settle();
        check("n8_desc", 128'(out8), 128'h0001_0304_0407_09FF);

        in4 = 32'hFE01_7F80;
        pol4 = 1'b0;
        settle();
        check("n4_unsigned_asc", 128'(out4), 128'hFE80_7F01);
        pol4 = 1'b1;
        settle();
        check("n4_unsigned_desc", 128'(out4), 128'h017F_80FE);

        in4 = 32'hAAAA_AAAA;
        pol4 = 1'b0;
        settle();
        check("n4_equal_asc", 128'(out4), 128'hAAAA_AAAA);
        pol4 = 1'b1;
        settle();
        check("n4_equal_desc", 128'(out4), 128'hAAAA_AAAA);

        in4 = 32'h4030_2010;
        pol4 = 1'b0;
        settle();
        check("n4_sorted_asc", 128'(out4), 128'h4030_2010);
        pol4 = 1'b1;
        settle();
        check("n4_sorted_desc", 128'(out4), 128'h1020_3040);

        // Simultaneous change of data and polarity.
        in4 = 32'h1020_3040;
        pol4 = 1'b0;
        settle();
        check("n4_simul_change", 128'(out4), 128'h4030_2010);

        // Reset held high across several edges while data changes.
        reset = 1'b1;
        pol8 = 1'b0;
        in8 = 64'h0102_0304_0506_0708;
        settle();
        check("rst_hold_0", 128'(out8), 128'h0807_0605_0403_0201);
        in8 = 64'h00FF_00FF_8080_7F7F;
        settle();
        check("rst_hold_1", 128'(out8), 128'hFFFF_8080_7F7F_0000);
        in8 = 64'h0404_00FF_0109_0307;
        settle();
        check("rst_hold_2", 128'(out8), 128'hFF09_0704_0403_0100);
        settle();
        check("rst_hold_3", 128'(out8), 128'hFF09_0704_0403_0100);
        reset = 1'b0;
        settle();
        check("rst_released", 128'(out8), 128'hFF09_0704_0403_0100);

        // Randomized 16-lane vectors against a reference insertion sort.
        for (int p = 0; p < 2; p++) begin
            for (int v = 0; v < 1000; v++) begin
                @(negedge clk);
                for (int i = 0; i < 16; i++) begin
                    // Narrow range on some vectors to force duplicates.
                    lanes[i] = (v % 4 == 0) ? 8'($urandom_range(0, 7))
                                            : 8'($urandom_range(0, 255));
                    in16[i*8 +: 8] = lanes[i];
                end
                pol16 = p[0];
                #1;
                for (int i = 0; i < 16; i++) sorted[i] = lanes[i];
                for (int i = 1; i < 16; i++) begin
                    for (int j = i; j > 0; j--) begin
                        if ((p == 0 && sorted[j-1] > sorted[j]) ||
                            (p == 1 && sorted[j-1] < sorted[j])) begin
                            tmp         = sorted[j];
                            sorted[j]   = sorted[j-1];
                            sorted[j-1] = tmp;
                        end
                    end
                end
                for (int i = 0; i < 16; i++) exp16[i*8 +: 8] = sorted[i];
                check(p == 0 ? "rand_asc" : "rand_desc", out16, exp16);

                for (int k = 0; k < 256; k++) hist[k] = 0;
                for (int i = 0; i < 16; i++) begin
                    hist[int'(lanes[i])]++;
                    hist[int'(out16[i*8 +: 8])]--;
                end
                perm_ok = 1'b1;
                for (int k = 0; k < 256; k++) if (hist[k] != 0) perm_ok = 1'b0;
                check("rand_perm", 128'(perm_ok), 128'd1);
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
